pc_fetch_controller: RTL and testbench

PC_FETCH_CONTROLLER -- requirements
Module: pc_fetch_controller

---
 rtl/pc_fetch_controller.sv | 182 ++++++++++++++++++
 tb/tb_pc_fetch_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: instruction-fetch sequencer sitting between the
// ProgramCounter, the instruction memory and the IF/ID pipeline register.
// It handles hazard stalls (with a one-entry skid buffer for data that was
// already returned), taken branches/jumps, traps, and redirects that arrive
// while a fetch is still outstanding.
module pc_fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,            // asynchronous, active-low
   input  logic [31:0] pc_out,
   input  logic        hazard_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        pc_write,
   output logic [31:0] next_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        misaligned
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] saved_target_q, saved_target_d;

   logic        pc_write_raw;
   logic        imem_req_raw;
   logic        redirect_any;
   logic        target_misaligned;
   logic [31:0] eff_target;
   logic [31:0] pc_plus4;

   // A trap outranks a branch; a misaligned branch target is turned into a trap.
   assign redirect_any      = trap | redirect_valid;
   assign target_misaligned = redirect_valid & ~trap & (redirect_target[1:0] != 2'b00);
   assign eff_target        = (trap | (redirect_target[1:0] != 2'b00)) ? TRAP_VECTOR
                                                                        : redirect_target;
   assign pc_plus4          = pc_out + 32'd4;   // wraps modulo 2^32

   // Next-state and PC/memory control, decided from the current state and inputs.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      pc_write_raw   = 1'b0;
      next_pc        = pc_plus4;
      imem_req_raw   = 1'b0;
      ifid_valid_d   = ifid_valid_q;
      ifid_pc_d      = ifid_pc_q;
      ifid_instr_d   = ifid_instr_q;
      skid_pc_d      = skid_pc_q;
      skid_instr_d   = skid_instr_q;
      saved_target_d = saved_target_q;
      misaligned_d   = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            pc_write_raw = 1'b1;
            next_pc      = RESET_VECTOR;
            state_d      = ST_FETCH;
         end

         ST_FETCH: begin
            imem_req_raw = 1'b1;
            if (redirect_any) begin
               ifid_valid_d = 1'b0;
               misaligned_d = target_misaligned;
               if (imem_ready) begin
                  pc_write_raw = 1'b1;
                  next_pc      = eff_target;
               end else begin
                  // Fetch still in flight: remember where to go once it returns.
                  saved_target_d = eff_target;
                  state_d        = ST_DRAIN;
               end
            end else if (imem_ready && hazard_stall) begin
               skid_pc_d    = pc_out;
               skid_instr_d = imem_rdata;
               state_d      = ST_HOLD;
            end else if (imem_ready) begin
               ifid_valid_d = 1'b1;
               ifid_pc_d    = pc_out;
               ifid_instr_d = imem_rdata;
               pc_write_raw = 1'b1;
               next_pc      = pc_plus4;
            end else if (!hazard_stall) begin
               // Memory not ready and decode is free: hand decode a bubble.
               ifid_valid_d = 1'b0;
            end
         end

         ST_HOLD: begin
            if (redirect_any) begin
               ifid_valid_d = 1'b0;
               misaligned_d = target_misaligned;
               pc_write_raw = 1'b1;
               next_pc      = eff_target;
               state_d      = ST_FETCH;
            end else if (!hazard_stall) begin
               ifid_valid_d = 1'b1;
               ifid_pc_d    = skid_pc_q;
               ifid_instr_d = skid_instr_q;
               pc_write_raw = 1'b1;
               next_pc      = pc_plus4;
               state_d      = ST_FETCH;
            end
         end

         ST_DRAIN: begin
            imem_req_raw = 1'b1;
            ifid_valid_d = 1'b0;
            if (redirect_any) begin
               saved_target_d = eff_target;
               misaligned_d   = target_misaligned;
            end
            if (imem_ready) begin
               pc_write_raw = 1'b1;
               next_pc      = redirect_any ? eff_target : saved_target_q;
               state_d      = ST_FETCH;
            end
         end

         default: state_d = ST_BOOT;
      endcase
   end

   // Gate the strobes with reset so they fall the moment reset asserts.
   assign pc_write  = pc_write_raw & reset;
   assign imem_req  = imem_req_raw & reset;
   assign imem_addr = pc_out;

   // State, IF/ID, skid and saved-target registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_BOOT;
         ifid_valid_q   <= 1'b0;
         ifid_pc_q      <= 32'h0;
         ifid_instr_q   <= NOP_INSTR;
         misaligned_q   <= 1'b0;
         skid_pc_q      <= 32'h0;
         skid_instr_q   <= 32'h0;
         saved_target_q <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q        <= state_d;
         ifid_valid_q   <= ifid_valid_d;
         ifid_pc_q      <= ifid_pc_d;
         ifid_instr_q   <= ifid_instr_d;
         misaligned_q   <= misaligned_d;
         skid_pc_q      <= skid_pc_d;
         skid_instr_q   <= skid_instr_d;
         saved_target_q <= saved_target_d;
      end
   end

   assign ifid_valid = ifid_valid_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_instr = ifid_instr_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Testbench for pc_fetch_controller: directed vector table, hand-written
// reset-during-drain sequence, then randomized traffic against a reference model.
module tb_pc_fetch_controller;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
   localparam logic [31:0] NOP          = 32'h0000_0013;
   localparam logic [31:0] JUNK         = 32'hBAD0_BAD0;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_out = 32'h0;
   logic        hazard_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        trap = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        pc_write;
   logic [31:0] next_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        misaligned;

   int tests_run = 0;
   int tests_failed = 0;

   // Stand-in for the ProgramCounter register, updated from expected values.
   logic [31:0] pc_r = 32'hDEAD_BEEC;

   pc_fetch_controller #(
      .RESET_VECTOR(RESET_VECTOR),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_out         (pc_out),
      .hazard_stall   (hazard_stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .trap           (trap),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .pc_write       (pc_write),
      .next_pc        (next_pc),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_instr     (ifid_instr),
      .misaligned     (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        rv;
      logic        trap;
      logic        ready;
      logic [31:0] target;
      logic [31:0] rdata;
      logic        exp_pw;
      logic [31:0] exp_npc;
      logic        exp_req;
      logic        exp_v;
      logic [31:0] exp_ipc;
      logic [31:0] exp_iinstr;
      logic        exp_mis;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check combinational outputs, clock, check registers.
   task automatic apply(input vec_t v, input string tag);
      hazard_stall    = v.stall;
      redirect_valid  = v.rv;
      trap            = v.trap;
      redirect_target = v.target;
      imem_ready      = v.ready;
      imem_rdata      = v.rdata;
      pc_out          = pc_r;
      #1;
      check({tag, ".imem_req"},  {31'h0, imem_req}, {31'h0, v.exp_req});
      check({tag, ".imem_addr"}, imem_addr, pc_r);
      check({tag, ".pc_write"},  {31'h0, pc_write}, {31'h0, v.exp_pw});
      if (v.exp_pw) check({tag, ".next_pc"}, next_pc, v.exp_npc);
      @(posedge clk);
      if (v.exp_pw) pc_r = v.exp_npc;
      #1;
      check({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, v.exp_v});
      check({tag, ".ifid_pc"},    ifid_pc, v.exp_ipc);
      check({tag, ".ifid_instr"}, ifid_instr, v.exp_iinstr);
      check({tag, ".misaligned"}, {31'h0, misaligned}, {31'h0, v.exp_mis});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".rst_pc_write"},   {31'h0, pc_write},   32'h0);
      check({tag, ".rst_next_pc"},    next_pc,             RESET_VECTOR);
      check({tag, ".rst_imem_req"},   {31'h0, imem_req},   32'h0);
      check({tag, ".rst_ifid_valid"}, {31'h0, ifid_valid}, 32'h0);
      check({tag, ".rst_ifid_pc"},    ifid_pc,             32'h0);
      check({tag, ".rst_ifid_instr"}, ifid_instr,          NOP);
      check({tag, ".rst_misaligned"}, {31'h0, misaligned}, 32'h0);
   endtask

   // ---------------- reference model (queue-based view of the fetch unit) ----
   bit          m_boot;
   logic [63:0] m_skid[$];     // returned-but-held {pc, instr}
   logic [31:0] m_pend[$];     // redirect waiting for an in-flight fetch
   logic        m_v;
   logic [31:0] m_ipc, m_iinstr;
   logic        m_mis;

   task automatic model_reset();
      m_boot = 1'b1;
      m_skid.delete();
      m_pend.delete();
      m_v = 1'b0; m_ipc = 32'h0; m_iinstr = NOP; m_mis = 1'b0;
   endtask

   // Fills the expected fields of v for the given inputs and advances the model.
   task automatic model_cycle(inout vec_t v);
      logic        redir, mis_now;
      logic [31:0] tgt, pc4;
      logic [63:0] e;
      redir   = v.trap | v.rv;
      tgt     = (v.trap || v.target[1:0] != 2'b00) ? TRAP_VECTOR : v.target;
      mis_now = v.rv && !v.trap && (v.target[1:0] != 2'b00);
      pc4     = pc_r + 32'd4;
      v.exp_pw = 1'b0; v.exp_npc = 32'h0; v.exp_req = 1'b0;
      m_mis = 1'b0;
      if (m_boot) begin
         v.exp_pw = 1'b1; v.exp_npc = RESET_VECTOR; m_boot = 1'b0;
      end else if (m_skid.size() != 0) begin
         if (redir) begin
            v.exp_pw = 1'b1; v.exp_npc = tgt; m_skid.delete(); m_v = 1'b0; m_mis = mis_now;
         end else if (!v.stall) begin
            e = m_skid.pop_front();
            v.exp_pw = 1'b1; v.exp_npc = pc4; m_v = 1'b1; m_ipc = e[63:32]; m_iinstr = e[31:0];
         end
      end else if (m_pend.size() != 0) begin
         v.exp_req = 1'b1; m_v = 1'b0;
         if (redir) begin m_pend[0] = tgt; m_mis = mis_now; end
         if (v.ready) begin v.exp_pw = 1'b1; v.exp_npc = m_pend.pop_front(); end
      end else begin
         v.exp_req = 1'b1;
         if (redir) begin
            m_v = 1'b0; m_mis = mis_now;
            if (v.ready) begin v.exp_pw = 1'b1; v.exp_npc = tgt; end
            else m_pend.push_back(tgt);
         end else if (v.ready && v.stall) begin
            m_skid.push_back({pc_r, v.rdata});
         end else if (v.ready) begin
            v.exp_pw = 1'b1; v.exp_npc = pc4; m_v = 1'b1; m_ipc = pc_r; m_iinstr = v.rdata;
         end else if (!v.stall) begin
            m_v = 1'b0;
         end
      end
      v.exp_v = m_v; v.exp_ipc = m_ipc; v.exp_iinstr = m_iinstr; v.exp_mis = m_mis;
   endtask

   function automatic logic [31:0] ins(input int n);
      return 32'h1000_0000 + 32'(n);
   endfunction

   // Hold reset, check the reset values, then release away from the clock edge.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      hazard_stall = 1'b0; redirect_valid = 1'b0; trap = 1'b0; imem_ready = 1'b0;
      #13;
      check_reset_outputs(tag);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   vec_t vecs[23];
   vec_t v;

   initial begin
      // Fields: stall rv trap ready target rdata | pw npc req | v ipc instr mis
      vecs[0]  = '{0,0,0,1,32'h0,JUNK,          1,32'h0,0,        0,32'h0,NOP,0};
      vecs[1]  = '{0,0,0,1,32'h0,ins(0),        1,32'h4,1,        1,32'h0,ins(0),0};
      vecs[2]  = '{0,0,0,1,32'h0,ins(1),        1,32'h8,1,        1,32'h4,ins(1),0};
      vecs[3]  = '{1,0,0,1,32'h0,ins(2),        0,32'h0,1,        1,32'h4,ins(1),0};
      vecs[4]  = '{1,0,0,1,32'h0,JUNK,          0,32'h0,0,        1,32'h4,ins(1),0};
      vecs[5]  = '{1,0,0,1,32'h0,JUNK,          0,32'h0,0,        1,32'h4,ins(1),0};
      vecs[6]  = '{0,0,0,1,32'h0,JUNK,          1,32'hC,0,        1,32'h8,ins(2),0};
      vecs[7]  = '{0,0,0,1,32'h0,ins(3),        1,32'h10,1,       1,32'hC,ins(3),0};
      vecs[8]  = '{0,1,0,0,32'h40,JUNK,         0,32'h0,1,        0,32'hC,ins(3),0};
      vecs[9]  = '{0,0,0,0,32'h0,JUNK,          0,32'h0,1,        0,32'hC,ins(3),0};
      vecs[10] = '{0,0,0,1,32'h0,JUNK,          1,32'h40,1,       0,32'hC,ins(3),0};
      vecs[11] = '{0,0,0,1,32'h0,ins(4),        1,32'h44,1,       1,32'h40,ins(4),0};
      vecs[12] = '{1,1,1,1,32'h80,JUNK,         1,32'h100,1,      0,32'h40,ins(4),0};
      vecs[13] = '{0,0,0,1,32'h0,ins(5),        1,32'h104,1,      1,32'h100,ins(5),0};
      vecs[14] = '{0,1,0,1,32'h42,JUNK,         1,32'h100,1,      0,32'h100,ins(5),1};
      vecs[15] = '{0,0,0,1,32'h0,ins(6),        1,32'h104,1,      1,32'h100,ins(6),0};
      vecs[16] = '{0,1,0,1,32'hFFFF_FFFC,JUNK,  1,32'hFFFF_FFFC,1, 0,32'h100,ins(6),0};
      vecs[17] = '{0,0,0,1,32'h0,ins(7),        1,32'h0,1,        1,32'hFFFF_FFFC,ins(7),0};
      vecs[18] = '{0,0,0,1,32'h0,ins(8),        1,32'h4,1,        1,32'h0,ins(8),0};
      vecs[19] = '{1,0,0,1,32'h0,ins(9),        0,32'h0,1,        1,32'h0,ins(8),0};
      vecs[20] = '{1,1,0,1,32'h200,JUNK,        1,32'h200,0,      0,32'h0,ins(8),0};
      vecs[21] = '{0,0,0,1,32'h0,ins(10),       1,32'h204,1,      1,32'h200,ins(10),0};
      vecs[22] = '{0,1,0,0,32'h300,JUNK,        0,32'h0,1,        0,32'h200,ins(10),0};

      do_reset("init");
      for (int i = 0; i < 23; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // Reset asserted while draining: imem_req must drop without waiting for an edge.
      redirect_valid = 1'b0; imem_ready = 1'b0;
      #2;
      check("drain.req_before_reset", {31'h0, imem_req}, 32'h1);
      reset = 1'b0;
      #1;
      check_reset_outputs("drain_reset");
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      v = '{0,0,0,1,32'h0,JUNK,   1,RESET_VECTOR,0, 0,32'h0,NOP,0};
      apply(v, "reboot");
      v = '{0,0,0,1,32'h0,ins(11), 1,32'h4,1,       1,32'h0,ins(11),0};
      apply(v, "refetch");

      // Randomized traffic against the reference model.
      do_reset("rand");
      for (int n = 0; n < 800; n++) begin
         v.stall  = ($urandom_range(0, 3) == 0);
         v.rv     = ($urandom_range(0, 5) == 0);
         v.trap   = ($urandom_range(0, 15) == 0);
         v.ready  = ($urandom_range(0, 2) != 0);
         v.target = {$urandom(), 2'b00} >> 0;
         v.target[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         v.rdata  = $urandom();
         model_cycle(v);
         apply(v, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
